lfsr_stream_engine: RTL
=======================

Name: lfsr_stream_engine

Overview:
- Parametrised successor to the single-bit random engine.
- Generates OUT_BITS pseudo-random bits per transfer from a WIDTH-bit Fibonacci LFSR with runtime tap mask and seed.
- Delivers each word over a val/rdy stream with backpressure.
- Runs free or for a programmed burst of LEN words, then pulses done.
- Sits between the control bus (start/stop/config) and any consumer of random words.

Parameters:
- WIDTH, 8, LFSR state width in bits (≥2).
- OUT_BITS, 8, bits produced per output word (1..WIDTH); state advances OUT_BITS steps per transfer.
- LEN_W, 16, width of the burst-length input and internal counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin generation; honoured only in IDLE
- stop  in  1  abort generation; honoured in RUN
- tap  in  WIDTH  feedback mask, sampled on accepted start
- seed  in  WIDTH  initial state, sampled on accepted start
- len  in  LEN_W  words to emit; 0 = free-running; sampled on accepted start
- active  out  1  high while in RUN
- out_val  out  1  out_data valid
- out_rdy  in  1  consumer accepts word
- out_data  out  OUT_BITS  random word; first-generated bit in MSB
- done  out  1  one-cycle pulse when a burst completes

Behaviour:
- Reset: state=IDLE; lfsr, tap_r, count=0; active=0, out_val=0, out_data=0, done=0. rst mid-RUN aborts immediately with no done pulse.
- Step function (one LFSR step):
  - emitted bit = s[WIDTH-1]
  - fb = XOR-reduce(s & tap_r)
  - s' = {s[WIDTH-2:0], fb}
- Word generation:
  - out_data is the OUT_BITS emitted bits of OUT_BITS consecutive steps from the current lfsr, first step in the MSB.
  - Computed combinationally, so there is zero latency from state to data.
- FSM state IDLE:
  - active=0, out_val=0.
  - start && !stop: lfsr<=(seed==0 ? 1 : seed), tap_r<=tap, count<=len, go RUN. The seed 0 substitution avoids an all-zero lock.
  - start && stop in the same cycle: stop wins, stay IDLE.
- FSM state RUN:
  - active=1, out_val=1.
  - Transfer = out_val && out_rdy: lfsr advances OUT_BITS steps; if count!=0 then count<=count-1.
  - No transfer: lfsr and out_data hold stable. Data must not change while val is high and rdy is low.
  - Transfer with count==1: go IDLE next cycle, done=1 for one cycle.
  - stop: go IDLE next cycle, no done. A transfer in the same cycle as stop still completes (word consumed, lfsr advances).
  - If stop coincides with the final transfer (count==1), done still pulses.
  - start in RUN is ignored.
- len=0 runs free until stop; count never decrements.
- First out_val rises the cycle after the accepted start; back-to-back transfers are possible every cycle.
- tap_r may drive lfsr to all-zero (e.g. tap=0). In that case the engine keeps emitting zeros; no recovery in the base build.

Optional Feature:
- Macro: LFSR_ZERO_RECOVER_EN.
- Defined:
  - Adds output stuck (1 bit, reset 0).
  - In RUN, a transfer whose next lfsr would be all-zero instead loads WIDTH'(1) and sets stuck sticky high.
  - stuck clears on the next accepted start or on rst.
- Undefined: no stuck port; all-zero state persists as in the base behaviour.

Decomposition:
- Package lfsr_pkg holds:
  - FSM state enum (IDLE, RUN)
  - function lfsr_step(s, tap), returning next state and emitted bit
  - default-parameter localparams
- Sub-module lfsr_word_gen (combinational):
  - Unrolls OUT_BITS lfsr_step calls.
  - Outputs word and next_state.
  - Shared with future multi-channel variants.
- Top holds the FSM, count, lfsr/tap registers and handshake.

Test Plan:
- WIDTH=8, OUT_BITS=8, tap=0xB8, seed=0x01, len=0, out_rdy=1 -> first word 0x01; the word after it is generated from lfsr=0x1C; out_val high every cycle.
- Same config, out_rdy=0 for 5 cycles after first val -> out_data held at 0x01 and lfsr held at 0x01; resumes on rdy.
- len=3, out_rdy=1 -> exactly 3 transfers; done pulses 1 cycle the cycle after the third; active and out_val go 0 the same cycle.
- seed=0x00 -> behaves identically to seed=0x01 (first word 0x01). With start&&stop together -> remains IDLE, active=0.
- Stop asserted with rdy=1 mid free run -> that word is consumed; IDLE next cycle; no done. rst during RUN -> all outputs 0 next cycle.
- LFSR_ZERO_RECOVER_EN, tap=0x00, seed=0x80, OUT_BITS=8 -> first word 0x80; state reloads 0x01 and stuck=1; the next start clears stuck.

Source files
------------

// File: rtl/lfsr_stream_engine_pkg.sv
// Shared types and the single-step Fibonacci LFSR function for lfsr_stream_engine.
// Optional build macro used by the engine: LFSR_ZERO_RECOVER_EN.
package lfsr_pkg;

  localparam int LFSR_WIDTH_DEF    = 8;
  localparam int LFSR_OUT_BITS_DEF = 8;
  localparam int LFSR_LEN_W_DEF    = 16;

  // Widest state the step function handles; narrower states are zero-extended.
  localparam int LFSR_MAX_W = 64;
  localparam int LFSR_IDX_W = $clog2(LFSR_MAX_W);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic [LFSR_MAX_W-1:0] next;
    logic                  bit_out;
  } step_t;

  function automatic step_t lfsr_step(input logic [LFSR_MAX_W-1:0] s,
                                      input logic [LFSR_MAX_W-1:0] tap,
                                      input int unsigned           width);
    step_t                 r;
    logic [LFSR_MAX_W-1:0] mask;
    mask      = (width >= LFSR_MAX_W) ? '1 : ((LFSR_MAX_W'(1) << width) - LFSR_MAX_W'(1));
    r.bit_out = s[LFSR_IDX_W'(width - 1)];
    r.next    = ((s << 1) | LFSR_MAX_W'(^(s & tap & mask))) & mask;
    return r;
  endfunction

endpackage

// File: rtl/lfsr_stream_engine_if.sv
// Valid/ready stream carrying one random word per transfer.
interface lfsr_stream_if #(
  parameter int OUT_BITS = lfsr_pkg::LFSR_OUT_BITS_DEF
) ();

  logic                out_val;
  logic                out_rdy;
  logic [OUT_BITS-1:0] out_data;

  modport master (output out_val, output out_data, input  out_rdy);
  modport slave  (input  out_val, input  out_data, output out_rdy);

endinterface

// File: rtl/lfsr_stream_engine_word_gen.sv
// Combinational unroll of OUT_BITS LFSR steps: the emitted word (first bit in MSB)
// and the state after the last step.
module lfsr_word_gen
  import lfsr_pkg::*;
#(
  parameter int WIDTH    = LFSR_WIDTH_DEF,
  parameter int OUT_BITS = LFSR_OUT_BITS_DEF
) (
  input  logic [WIDTH-1:0]    state,
  input  logic [WIDTH-1:0]    tap,
  output logic [OUT_BITS-1:0] word,
  output logic [WIDTH-1:0]    next_state
);

  // NOTE: blocking assignments inside always_comb, and every output gets a
  // default before the loop so no path can leave a latch behind.
  always_comb begin
    step_t                 r;
    logic [LFSR_MAX_W-1:0] s;
    r    = '0;
    s    = LFSR_MAX_W'(state);
    word = '0;
    for (int i = 0; i < OUT_BITS; i++) begin
      r                    = lfsr_step(s, LFSR_MAX_W'(tap), WIDTH);
      word[OUT_BITS-1-i]   = r.bit_out;
      s                    = r.next;
    end
    next_state = s[WIDTH-1:0];
  end

endmodule

// File: rtl/lfsr_stream_engine.sv
// Burst/free-running LFSR word generator with a val/rdy output stream.
// Build macro LFSR_ZERO_RECOVER_EN adds the stuck output and all-zero state recovery.
module lfsr_stream_engine
  import lfsr_pkg::*;
#(
  parameter int WIDTH    = LFSR_WIDTH_DEF,
  parameter int OUT_BITS = LFSR_OUT_BITS_DEF,
  parameter int LEN_W    = LFSR_LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] tap,
  input  logic [WIDTH-1:0] seed,
  input  logic [LEN_W-1:0] len,
  output logic             active,
  output logic             done,
`ifdef LFSR_ZERO_RECOVER_EN
  output logic             stuck,
`endif
  lfsr_stream_if.master    stream
);

  if (WIDTH < 2 || WIDTH > LFSR_MAX_W) begin : g_bad_width
    $error("lfsr_stream_engine: WIDTH out of range");
  end
  if (OUT_BITS < 1 || OUT_BITS > WIDTH) begin : g_bad_out_bits
    $error("lfsr_stream_engine: OUT_BITS out of range");
  end

  state_e              state;
  logic [WIDTH-1:0]    lfsr;
  logic [WIDTH-1:0]    tap_r;
  logic [WIDTH-1:0]    next_lfsr;
  logic [LEN_W-1:0]    count;
  logic [OUT_BITS-1:0] word;
  logic                val_r;
  logic                xfer;

  lfsr_word_gen #(
    .WIDTH    (WIDTH),
    .OUT_BITS (OUT_BITS)
  ) u_word_gen (
    .state      (lfsr),
    .tap        (tap_r),
    .word       (word),
    .next_state (next_lfsr)
  );

  // Data comes straight from the held state, so it cannot move during a stall.
  assign stream.out_data = word;
  assign stream.out_val  = val_r;
  assign xfer            = val_r && stream.out_rdy;

  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      lfsr   <= '0;
      tap_r  <= '0;
      count  <= '0;
      active <= 1'b0;
      val_r  <= 1'b0;
      done   <= 1'b0;
`ifdef LFSR_ZERO_RECOVER_EN
      stuck  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !stop) begin
            lfsr   <= (seed == '0) ? WIDTH'(1) : seed;
            tap_r  <= tap;
            count  <= len;
            state  <= RUN;
            active <= 1'b1;
            val_r  <= 1'b1;
`ifdef LFSR_ZERO_RECOVER_EN
            stuck  <= 1'b0;
`endif
          end
        end

        RUN: begin
          if (xfer) begin
`ifdef LFSR_ZERO_RECOVER_EN
            if (next_lfsr == '0) begin
              lfsr  <= WIDTH'(1);
              stuck <= 1'b1;
            end else begin
              lfsr  <= next_lfsr;
            end
`else
            lfsr <= next_lfsr;
`endif
            if (count != '0) count <= count - LEN_W'(1);
          end
          // Completing the last word of a burst wins over a coincident stop.
          if (xfer && count == LEN_W'(1)) begin
            state  <= IDLE;
            active <= 1'b0;
            val_r  <= 1'b0;
            done   <= 1'b1;
          end else if (stop) begin
            state  <= IDLE;
            active <= 1'b0;
            val_r  <= 1'b0;
          end
        end

        default: begin
          state  <= IDLE;
          active <= 1'b0;
          val_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule
